// File: rtl/axi_burst_sequencer_if.sv
// Command/beat bundle between an AXI address channel front-end and the memory-port sequencer.
// The sequencer takes the slave side; the address-channel logic (or a bench) takes the master side.
interface axi_burst_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_BYTES = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [2:0]            cmd_size;
  logic [1:0]            cmd_burst;
  logic                  beat_valid;
  logic                  beat_ready;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_BYTES-1:0] beat_lanes;
  logic [LEN_WIDTH-1:0]  beat_idx;
  logic                  beat_last;
  logic                  beat_err;
  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_addr, beat_lanes, beat_idx, beat_last, beat_err, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_addr, beat_lanes, beat_idx, beat_last, beat_err, busy
  );
endinterface

// File: rtl/axi_burst_sequencer.sv
// Walks one AXI address command beat by beat, producing per-beat address, byte lanes,
// index, last and error flags for a memory port.

// One byte lane: active when off <= LANE < lim.
module axi_burst_lane #(
  parameter int LANE = 0
) (
  input  logic [9:0] off,
  input  logic [9:0] lim,
  output logic       en
);
  assign en = (10'(LANE) >= off) && (10'(LANE) < lim);
endmodule

module axi_burst_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_burst_sequencer_if.slave    bus
);
  localparam int AW      = ADDR_WIDTH;
  localparam int LOG2_DB = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10, B_RSVD = 2'b11} burst_t;
  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [AW-1:0]        wrap_lo;
    logic [AW-1:0]        wrap_hi;
    logic [LEN_WIDTH-1:0] len;
    logic [2:0]           size;
    burst_t               burst;
  } cmd_t;

  state_t state;
  cmd_t   cmd_q;

  // Command decode at capture time
  logic [AW-1:0] cmd_bytes, cmd_total, cmd_aligned, cmd_lower;
  logic [AW:0]   cmd_end;
  logic          cmd_cross, cmd_err;

  always_comb begin
    cmd_bytes   = AW'(1) << bus.cmd_size;
    cmd_total   = (AW'(bus.cmd_len) + AW'(1)) << bus.cmd_size;
    cmd_aligned = bus.cmd_addr & ~(cmd_bytes - AW'(1));
    cmd_lower   = bus.cmd_addr & ~(cmd_total - AW'(1));
    // One extra bit so a burst running off the top of the address space still counts as a crossing
    cmd_end     = {1'b0, cmd_aligned} + {1'b0, cmd_total} - (AW+1)'(1);
    cmd_cross   = cmd_end[AW:12] != {1'b0, cmd_aligned[AW-1:12]};
    cmd_err     = 1'b0;
    if (32'(bus.cmd_size) > LOG2_DB) cmd_err = 1'b1;
    case (burst_t'(bus.cmd_burst))
      B_FIXED: if (32'(bus.cmd_len) > 15) cmd_err = 1'b1;
      B_INCR:  if (cmd_cross) cmd_err = 1'b1;
      B_WRAP:  if (!(32'(bus.cmd_len) inside {1, 3, 7, 15}) ||
                   ((bus.cmd_addr & (cmd_bytes - AW'(1))) != '0)) cmd_err = 1'b1;
      default: cmd_err = 1'b1;
    endcase
  end

  // Next beat address from the current one
  logic [AW-1:0] bytes_q, aligned_cur, incr_addr, next_addr;

  always_comb begin
    bytes_q     = AW'(1) << cmd_q.size;
    aligned_cur = bus.beat_addr & ~(bytes_q - AW'(1));
    incr_addr   = aligned_cur + bytes_q;
    case (cmd_q.burst)
      B_FIXED: next_addr = bus.beat_addr;
      B_WRAP:  next_addr = (incr_addr == cmd_q.wrap_hi) ? cmd_q.wrap_lo : incr_addr;
      default: next_addr = incr_addr;
    endcase
  end

  // Lane mask is computed for whichever address gets registered next
  logic [AW-1:0]         lane_addr, lane_aligned;
  logic [2:0]            lane_size;
  logic [9:0]            lane_off, lane_lim;
  logic [DATA_BYTES-1:0] lane_mask;

  always_comb begin
    lane_addr    = (state == IDLE) ? bus.cmd_addr : next_addr;
    lane_size    = (state == IDLE) ? bus.cmd_size : cmd_q.size;
    lane_aligned = lane_addr & ~((AW'(1) << lane_size) - AW'(1));
    lane_off     = 10'(lane_addr & AW'(DATA_BYTES - 1));
    lane_lim     = 10'(lane_aligned & AW'(DATA_BYTES - 1)) + (10'(1) << lane_size);
  end

  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
    axi_burst_lane #(.LANE(g)) u_lane (
      .off (lane_off),
      .lim (lane_lim),
      .en  (lane_mask[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cmd_q          <= '0;
      bus.cmd_ready  <= 1'b1;
      bus.beat_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.beat_addr  <= '0;
      bus.beat_lanes <= '0;
      bus.beat_idx   <= '0;
      bus.beat_last  <= 1'b0;
      bus.beat_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
          cmd_q          <= '{wrap_lo: cmd_lower,
                              wrap_hi: cmd_lower + cmd_total,
                              len:     bus.cmd_len,
                              size:    bus.cmd_size,
                              burst:   burst_t'(bus.cmd_burst)};
          bus.beat_addr  <= bus.cmd_addr;
          bus.beat_lanes <= lane_mask;
          bus.beat_idx   <= '0;
          bus.beat_last  <= (bus.cmd_len == '0);
          bus.beat_err   <= cmd_err;
          bus.beat_valid <= 1'b1;
          bus.busy       <= 1'b1;
          bus.cmd_ready  <= 1'b0;
          state          <= BURST;
        end
        BURST: if (bus.beat_ready) begin
          if (bus.beat_last) begin
            bus.beat_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.cmd_ready  <= 1'b1;
            state          <= IDLE;
          end else begin
            bus.beat_addr  <= next_addr;
            bus.beat_lanes <= lane_mask;
            bus.beat_idx   <= bus.beat_idx + LEN_WIDTH'(1);
            bus.beat_last  <= (bus.beat_idx + LEN_WIDTH'(1)) == cmd_q.len;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
